// File: rtl/cpu_multicycle.sv
// Multicycle RV32I core: FETCH -> EXEC -> (MEM) -> WB, one instruction at a time.
// Define CPU_MC_PERF_EN to add the perf_cycle / perf_instret counters.
module cpu_multicycle #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [2:0]  dmem_op,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        retire,
    output logic        halted
`ifdef CPU_MC_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_cycle,
    output logic [CNT_WIDTH-1:0] perf_instret
`endif
);

    typedef enum logic [2:0] {StFetch, StExec, StMem, StWb, StHalt} state_e;

    state_e      r_state, w_state_next;
    logic        r_boot;
    logic [31:0] r_pc, r_ir, r_result, r_npc, r_wdata;
    logic        r_wr;
    logic [31:0] r_regs [32];

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd;
    logic [31:0] w_rs1v, w_rs2v, w_pc4;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_alu_b, w_alu;
    logic        w_br_taken;
    logic [31:0] w_result, w_npc;
    logic        w_wr, w_mem, w_ebreak;

    assign w_opcode = r_ir[6:0];
    assign w_f3     = r_ir[14:12];
    assign w_rd     = r_ir[11:7];
    assign w_rs1v   = (r_ir[19:15] == 5'd0) ? 32'd0 : r_regs[r_ir[19:15]];
    assign w_rs2v   = (r_ir[24:20] == 5'd0) ? 32'd0 : r_regs[r_ir[24:20]];
    assign w_pc4    = r_pc + 32'd4;

    assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_u = {r_ir[31:12], 12'b0};
    assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

    assign w_alu_b = (w_opcode == 7'b0110011) ? w_rs2v : w_imm_i;

    always_comb begin
        w_alu = 32'd0;
        unique case (w_f3)
            3'b000: w_alu = (w_opcode == 7'b0110011 && r_ir[30]) ? w_rs1v - w_alu_b
                                                                  : w_rs1v + w_alu_b;
            3'b001: w_alu = w_rs1v << w_alu_b[4:0];
            3'b010: w_alu = {31'd0, $signed(w_rs1v) < $signed(w_alu_b)};
            3'b011: w_alu = {31'd0, w_rs1v < w_alu_b};
            3'b100: w_alu = w_rs1v ^ w_alu_b;
            3'b101: w_alu = r_ir[30] ? $unsigned($signed(w_rs1v) >>> w_alu_b[4:0])
                                     : w_rs1v >> w_alu_b[4:0];
            3'b110: w_alu = w_rs1v | w_alu_b;
            3'b111: w_alu = w_rs1v & w_alu_b;
            default: w_alu = 32'd0;
        endcase
    end

    always_comb begin
        w_br_taken = 1'b0;
        case (w_f3)
            3'b000: w_br_taken = (w_rs1v == w_rs2v);
            3'b001: w_br_taken = (w_rs1v != w_rs2v);
            3'b100: w_br_taken = ($signed(w_rs1v) < $signed(w_rs2v));
            3'b101: w_br_taken = ($signed(w_rs1v) >= $signed(w_rs2v));
            3'b110: w_br_taken = (w_rs1v < w_rs2v);
            3'b111: w_br_taken = (w_rs1v >= w_rs2v);
            default: w_br_taken = 1'b0;
        endcase
    end

    // Anything not matched below falls through as a NOP.
    always_comb begin
        w_result = w_alu;
        w_npc    = w_pc4;
        w_wr     = 1'b0;
        w_mem    = 1'b0;
        w_ebreak = 1'b0;
        case (w_opcode)
            7'b0110111: begin w_result = w_imm_u; w_wr = 1'b1; end
            7'b0010111: begin w_result = r_pc + w_imm_u; w_wr = 1'b1; end
            7'b1101111: begin w_result = w_pc4; w_npc = r_pc + w_imm_j; w_wr = 1'b1; end
            7'b1100111: if (w_f3 == 3'b000) begin
                w_result = w_pc4;
                w_npc    = (w_rs1v + w_imm_i) & ~32'd1;
                w_wr     = 1'b1;
            end
            7'b1100011: if (w_br_taken) w_npc = r_pc + w_imm_b;
            7'b0000011: if (w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                w_result = w_rs1v + w_imm_i;
                w_mem    = 1'b1;
                w_wr     = 1'b1;
            end
            7'b0100011: if (w_f3 inside {3'b000, 3'b001, 3'b010}) begin
                w_result = w_rs1v + w_imm_s;
                w_mem    = 1'b1;
            end
            7'b0010011, 7'b0110011: w_wr = 1'b1;
            7'b1110011: w_ebreak = (r_ir == 32'h0010_0073);
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StFetch: if (!r_boot && imem_ack) w_state_next = StExec;
            StExec:  w_state_next = w_ebreak ? StHalt : (w_mem ? StMem : StWb);
            StMem:   if (dmem_ack) w_state_next = StWb;
            StWb:    w_state_next = StFetch;
            StHalt:  w_state_next = StHalt;
            default: w_state_next = StFetch;
        endcase
    end

    // r_boot keeps requests low for the cycle right after a reset edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StFetch;
            r_pc    <= RESET_VECTOR;
            r_boot  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_boot  <= 1'b0;
            if (r_state == StWb) r_pc <= r_npc;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            case (r_state)
                StFetch: if (!r_boot && imem_ack) r_ir <= imem_rdata;
                StExec: begin
                    r_result <= w_result;
                    r_npc    <= w_npc;
                    r_wr     <= w_wr;
                    r_wdata  <= w_rs2v;
                end
                StMem: if (dmem_ack && !r_ir[5]) r_result <= dmem_rdata;
                StWb: if (r_wr && w_rd != 5'd0) r_regs[w_rd] <= r_result;
                default: ;
            endcase
        end
    end

    assign imem_req   = (r_state == StFetch) && !r_boot;
    assign imem_addr  = r_pc;
    assign dmem_req   = (r_state == StMem);
    assign dmem_we    = r_ir[5];
    assign dmem_op    = w_f3;
    assign dmem_addr  = r_result;
    assign dmem_wdata = r_wdata;
    assign retire     = (r_state == StWb);
    assign halted     = (r_state == StHalt);

`ifdef CPU_MC_PERF_EN
    logic [CNT_WIDTH-1:0] r_perf_cycle, r_perf_instret;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_cycle   <= '0;
            r_perf_instret <= '0;
        end else begin
            if (r_state != StHalt) r_perf_cycle <= r_perf_cycle + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (retire) r_perf_instret <= r_perf_instret + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign perf_cycle   = r_perf_cycle;
    assign perf_instret = r_perf_instret;
`else
    // Keeps CNT_WIDTH referenced when the counters are compiled out.
    if (CNT_WIDTH == 0) begin : g_cnt_width_unused
    end
`endif

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: register results are observed through store data.
module tb_cpu_multicycle;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'd0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [2:0]  dmem_op;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'd0;
    logic        retire, halted;
`ifdef CPU_MC_PERF_EN
    logic [3:0]  perf_cycle, perf_instret;
`endif

    int n_total = 0;
    int n_bad   = 0;

    cpu_multicycle #(
        .RESET_VECTOR(32'h100)
`ifdef CPU_MC_PERF_EN
        ,
        .CNT_WIDTH(4)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_op(dmem_op),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .retire(retire),
        .halted(halted)
`ifdef CPU_MC_PERF_EN
        ,
        .perf_cycle(perf_cycle),
        .perf_instret(perf_instret)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_eq("rst_imem_req", imem_req, 0);
        check_eq("rst_dmem_req", dmem_req, 0);
        check_eq("rst_retire", retire, 0);
        check_eq("rst_halted", halted, 0);
        reset = 1'b0;
    endtask

    // Waits (bounded) for a fetch, checks the address, acks after 'delay' extra cycles.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr, input int delay);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_eq("fetch_req", imem_req, 1);
        check_eq("imem_addr", imem_addr, pc);
        repeat (delay) begin
            @(negedge clock);
            check_eq("imem_addr_hold", imem_addr, pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = instr;
        @(negedge clock);
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        check_eq("exec_no_retire", retire, 0);
    endtask

    task automatic step_alu(input logic [31:0] pc, input logic [31:0] instr);
        fetch(pc, instr, 0);
        @(negedge clock);
        check_eq("wb_retire", retire, 1);
        check_eq("wb_no_dmem", dmem_req, 0);
    endtask

    task automatic step_mem(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int n);
        fetch(pc, instr, 0);
        @(negedge clock);
        for (int k = 0; k < n; k++) begin
            check_eq("dmem_req", dmem_req, 1);
            check_eq("dmem_addr", dmem_addr, addr);
            check_eq("dmem_we", dmem_we, we);
            check_eq("dmem_op", dmem_op, instr[14:12]);
            if (we) check_eq("dmem_wdata", dmem_wdata, wdata);
            if (k == n - 1) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge clock);
        end
        dmem_ack = 1'b0;
        check_eq("mem_retire", retire, 1);
        check_eq("mem_req_drop", dmem_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        do_reset();
`ifdef CPU_MC_PERF_EN
        check_eq("perf_cycle_rst", perf_cycle, 0);
`endif
        step_alu(32'h100, 32'h0050_0093);                                 // addi x1,x0,5
        step_mem(32'h104, 32'h0010_2423, 1, 32'd8, 32'd5, 32'd0, 3);      // sw x1,8(x0)
        step_alu(32'h108, 32'h0020_8167);                                 // jalr x2,x1,2
        step_mem(32'h006, 32'h0020_2623, 1, 32'd12, 32'h10C, 32'd0, 1);   // sw x2,12(x0)
        step_mem(32'h00A, 32'h0040_A183, 0, 32'd9, 32'd0, 32'hDEAD_BEEF, 2); // lw x3,4(x1)
        step_alu(32'h00E, 32'hFFFF_FFFF);                                 // unknown -> nop
        step_alu(32'h012, 32'h0011_8233);                                 // add x4,x3,x1
        step_alu(32'h016, 32'h4030_82B3);                                 // sub x5,x1,x3
        step_mem(32'h01A, 32'h0040_2023, 1, 32'd0, 32'hDEAD_BEF4, 32'd0, 1);
        step_mem(32'h01E, 32'h0050_2023, 1, 32'd0, 32'h2152_4116, 32'd0, 1);
        step_alu(32'h022, 32'h0070_0013);                                 // addi x0,x0,7
        step_mem(32'h026, 32'h0000_2023, 1, 32'd0, 32'd0, 32'd0, 1);      // sw x0
        step_alu(32'h02A, 32'h0000_0067);                                 // jalr x0,x0,0
        step_alu(32'h000, 32'hFE00_0CE3);                                 // beq x0,x0,-8
        step_alu(32'hFFFF_FFF8, 32'hFE00_1CE3);                           // bne not taken
        step_alu(32'hFFFF_FFFC, 32'h0080_03EF);                           // jal x7,+8
        step_mem(32'h004, 32'h0070_2023, 1, 32'd0, 32'd0, 32'd0, 1);      // sw x7 (wrapped 0)
        step_alu(32'h008, 32'h1234_5437);                                 // lui x8
        step_mem(32'h00C, 32'h0080_2023, 1, 32'd0, 32'h1234_5000, 32'd0, 1);
        step_alu(32'h010, 32'h0012_4463);                                 // blt x4,x1 taken
        step_alu(32'h018, 32'h0012_6463);                                 // bltu x4,x1 not taken

        // Reset lands together with dmem_ack mid-MEM: the load must be dropped.
        fetch(32'h01C, 32'h0000_2083, 0);                                 // lw x1,0(x0)
        @(negedge clock);
        check_eq("mid_mem_req", dmem_req, 1);
        reset      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h55;
        @(negedge clock);
        check_eq("rstmem_dmem_req", dmem_req, 0);
        check_eq("rstmem_imem_req", imem_req, 0);
        check_eq("rstmem_retire", retire, 0);
        reset    = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clock);
        check_eq("boot_req", imem_req, 1);
        check_eq("boot_addr", imem_addr, 32'h100);
        step_mem(32'h100, 32'h0010_2423, 1, 32'd8, 32'd5, 32'd0, 1);      // x1 still 5

        // EBREAK halts; stray acks are ignored.
        fetch(32'h104, 32'h0010_0073, 0);
        quiet = 0;
        for (int i = 0; i < 100; i++) begin
            imem_ack = i[0];
            dmem_ack = i[1];
            @(negedge clock);
            if (imem_req || dmem_req || retire || !halted) quiet++;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        check_eq("halt_quiet", quiet, 0);
        check_eq("halted", halted, 1);
        do_reset();
        step_alu(32'h100, 32'h0050_0093);

`ifdef CPU_MC_PERF_EN
        do_reset();
        check_eq("instret_rst", perf_instret, 0);
        for (int i = 0; i < 16; i++) step_alu(32'h100 + 32'(4 * i), 32'h0070_0013);
        @(negedge clock);
        check_eq("instret_wrap", perf_instret, 0);
        step_mem(32'h140, 32'h0000_2023, 1, 32'd0, 32'd0, 32'd0, 1);      // x0 reads 0
        @(negedge clock);
        check_eq("instret_one", perf_instret, 1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
